// File: rtl/bcd_serial_adder_if.sv
// Operand/result bundle for the digit-serial BCD adder; master is the operand source.
interface bcd_serial_adder_if #(
  parameter int DIGITS = 4
);
  logic                  start;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic                  cin;
  logic                  sub;
  logic                  ready;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   sum;
  logic                  cout;
  logic                  err;

  modport master (
    output start, a, b, cin, sub,
    input  ready, busy, done, sum, cout, err
  );

  modport slave (
    input  start, a, b, cin, sub,
    output ready, busy, done, sum, cout, err
  );
endinterface

// File: rtl/bcd_serial_adder.sv
// Digit-serial BCD add / 9's-complement subtract, LSD first; done pulses DIGITS cycles after accept.
// start is ignored while busy; define BCD_INPUT_CHECK_EN for a sticky invalid-digit err flag.
module bcd_serial_adder #(
  parameter int DIGITS = 4
) (
  input  logic              clk,
  input  logic              rst,
  bcd_serial_adder_if.slave bus
);
  localparam int W     = 4 * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [W-1:0]      a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic              sub_q, sub_d, carry_q, carry_d, cout_q, cout_d;
  logic              done_q, done_d, ready_q, ready_d, busy_q, busy_d;

  logic [3:0]        a_dig, b_dig, bd, dig;
  logic [4:0]        t;
  logic              carry_nxt, last;

  // Current digit datapath; 5-bit sum so 9+9+1 and invalid digits never wrap.
  always_comb begin
    a_dig = a_q[3:0];
    b_dig = b_q[3:0];
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_dig = a_q[4*i +: 4];
        b_dig = b_q[4*i +: 4];
      end
    end
    bd        = sub_q ? (4'd9 - b_dig) : b_dig;
    t         = {1'b0, a_dig} + {1'b0, bd} + {4'b0, carry_q};
    carry_nxt = (t > 5'd9);
    dig       = carry_nxt ? 4'(t - 5'd10) : t[3:0];
    last      = (idx_q == IDX_W'(DIGITS - 1));
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          sub_d   = bus.sub;
          carry_d = bus.cin;
          idx_d   = '0;
          sum_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < DIGITS; i++) begin
          if (idx_q == IDX_W'(i)) sum_d[4*i +: 4] = dig;
        end
        carry_d = carry_nxt;
        idx_d   = idx_q + IDX_W'(1);
        if (last) begin
          cout_d  = carry_nxt;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
    endcase
    ready_d = (state_d == IDLE);
    busy_d  = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      done_q  <= done_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

`ifdef BCD_INPUT_CHECK_EN
  logic err_q, err_d;

  // Checks raw b, before complementing; arithmetic is unaffected.
  always_comb begin
    err_d = err_q;
    if (state_q == IDLE && bus.start)
      err_d = 1'b0;
    else if (state_q == RUN && (a_dig > 4'd9 || b_dig > 4'd9))
      err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.ready = ready_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.sum   = sum_q;
  assign bus.cout  = cout_q;
endmodule

// File: tb/tb_bcd_serial_adder.sv
// Directed and randomized bench for bcd_serial_adder, checked against a decimal-arithmetic model.
module tb_bcd_serial_adder;
  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  bcd_serial_adder_if #(.DIGITS(DIGITS)) bus ();

  bcd_serial_adder #(.DIGITS(DIGITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic int pow10(input int n);
    int p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  function automatic int bcd2int(input logic [W-1:0] v);
    int r = 0;
    for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int x);
    logic [W-1:0] v = '0;
    for (int i = 0; i < DIGITS; i++) begin
      v[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return v;
  endfunction

  function automatic logic has_bad_digit(input logic [W-1:0] v);
    logic bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) if (v[4*i +: 4] > 4'd9) bad = 1'b1;
    return bad;
  endfunction

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] v = '0;
    for (int i = 0; i < DIGITS; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
    return v;
  endfunction

  // Called at a negedge with the DUT ready; returns at the negedge where done is seen.
  task automatic run_op(input logic [W-1:0] a_v, input logic [W-1:0] b_v,
                        input logic cin_v, input logic sub_v,
                        input bit check_sum, input bit glitch, input string tag);
    int  p, bv, r, k, busy_cnt;
    logic exp_err;
    bus.a     = a_v;
    bus.b     = b_v;
    bus.cin   = cin_v;
    bus.sub   = sub_v;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    k = 1;
    busy_cnt = 0;
    while (!bus.done && k < 20) begin
      if (bus.busy) busy_cnt++;
      if (glitch && (k == 2 || k == 3)) begin
        bus.start = 1'b1;
        bus.a     = rand_bcd();
        bus.b     = rand_bcd();
        bus.cin   = ~cin_v;
        bus.sub   = ~sub_v;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    bus.start = 1'b0;
    p  = pow10(DIGITS);
    bv = sub_v ? (p - 1 - bcd2int(b_v)) : bcd2int(b_v);
    r  = bcd2int(a_v) + bv + int'(cin_v);
`ifdef BCD_INPUT_CHECK_EN
    exp_err = has_bad_digit(a_v) | has_bad_digit(b_v);
`else
    exp_err = 1'b0;
`endif
    check({tag, ".latency"}, 64'(k - 1), 64'(DIGITS));
    check({tag, ".busy_cycles"}, 64'(busy_cnt), 64'(DIGITS));
    check({tag, ".ready_at_done"}, 64'(bus.ready), 64'd1);
    if (check_sum) begin
      check({tag, ".sum"}, 64'(bus.sum), 64'(int2bcd(r % p)));
      check({tag, ".cout"}, 64'(bus.cout), 64'(r >= p));
    end
    check({tag, ".err"}, 64'(bus.err), 64'(exp_err));
  endtask

  initial begin
    int k;
    bit seen_done;
    n_checks  = 0;
    n_pass    = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
    bus.sub   = 1'b0;
    repeat (3) @(negedge clk);
    check("reset.ready", 64'(bus.ready), 64'd1);
    check("reset.busy",  64'(bus.busy),  64'd0);
    check("reset.done",  64'(bus.done),  64'd0);
    check("reset.sum",   64'(bus.sum),   64'd0);
    check("reset.cout",  64'(bus.cout),  64'd0);
    check("reset.err",   64'(bus.err),   64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op(16'h1234, 16'h5678, 1'b0, 1'b0, 1'b1, 1'b0, "add_basic");
    check("add_basic.sum_const", 64'(bus.sum), 64'h6912);
    @(negedge clk);
    check("done_pulse_width", 64'(bus.done), 64'd0);
    check("hold.sum", 64'(bus.sum), 64'h6912);

    run_op(16'h9999, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0, "ripple");
    @(negedge clk);
    run_op(16'h9999, 16'h9999, 1'b1, 1'b0, 1'b1, 1'b0, "max_add");
    @(negedge clk);
    run_op(16'h0500, 16'h0123, 1'b1, 1'b1, 1'b1, 1'b0, "sub_pos");
    check("sub_pos.sum_const", 64'(bus.sum), 64'h0377);
    @(negedge clk);
    run_op(16'h0123, 16'h0500, 1'b1, 1'b1, 1'b1, 1'b0, "sub_neg");
    check("sub_neg.sum_const", 64'(bus.sum), 64'h9623);
    @(negedge clk);

    // start pulses mid-RUN must be ignored; the op after it starts in the done cycle
    run_op(16'h4321, 16'h1111, 1'b0, 1'b0, 1'b1, 1'b1, "start_ignored");
    run_op(16'h0707, 16'h0303, 1'b0, 1'b0, 1'b1, 1'b0, "back_to_back");
    @(negedge clk);

    // reset in RUN cycle 2 aborts with no later done
    bus.a = 16'h5555; bus.b = 16'h4444; bus.cin = 1'b0; bus.sub = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort.sum",   64'(bus.sum),   64'd0);
    check("abort.cout",  64'(bus.cout),  64'd0);
    check("abort.done",  64'(bus.done),  64'd0);
    check("abort.busy",  64'(bus.busy),  64'd0);
    check("abort.ready", 64'(bus.ready), 64'd1);
    seen_done = 1'b0;
    for (k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.done) seen_done = 1'b1;
    end
    check("abort.no_done", 64'(seen_done), 64'd0);

    run_op(16'h12A4, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, "bad_digit");
    @(negedge clk);
    run_op(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0, "after_bad");
    check("after_bad.sum_const", 64'(bus.sum), 64'h0002);

    for (int n = 0; n < 24; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_op(rand_bcd(), rand_bcd(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'b1, 1'($urandom_range(0, 3) == 0), $sformatf("rand%0d", n));
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
